// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder; ovf present with PIPE_ADD_OVF_EN
interface pipelined_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         co;
`ifdef PIPE_ADD_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, a0, a1, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );
    modport slave (
        input  in_valid, a0, a1, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
`else
    modport master (
        output in_valid, a0, a1, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co
    );
    modport slave (
        input  in_valid, a0, a1, ci, sub, out_ready,
        output in_ready, out_valid, sum, co
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - N-bit add/sub with carry chain split over STAGES registered chunks; PIPE_ADD_OVF_EN adds signed overflow
module pipelined_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);
    localparam int CHUNK = N / STAGES;

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: N must be a multiple of STAGES");
    end

    // en[STAGES] is the downstream accept; each stage may load when empty or when the one after it moves
    logic [STAGES:0] en;
    assign en[STAGES]   = bus.out_ready;
    assign bus.in_ready = en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int YIN = N - k * CHUNK;

        logic [N-1:0]     x_in;
        logic [N-1:0]     x_d;
        logic [N-1:0]     x_q;
        logic [YIN-1:0]   y_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] s_d;
        logic             c_d;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_first
            assign x_in = bus.a0;
            assign y_in = bus.a1 ^ {N{bus.sub}};
            assign c_in = bus.ci ^ bus.sub;
            assign v_in = bus.in_valid;
        end else begin : g_next
            assign x_in = g_stage[k-1].x_q;
            assign y_in = g_stage[k-1].g_fwd.y_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        assign {c_d, s_d} = {1'b0, x_in[k*CHUNK +: CHUNK]}
                          + {1'b0, y_in[CHUNK-1:0]}
                          + {{CHUNK{1'b0}}, c_in};

        // x carries finished sum chunks below k and untouched a0 chunks above
        always_comb begin
            x_d = x_in;
            x_d[k*CHUNK +: CHUNK] = s_d;
        end

        assign en[k] = !v_q | en[k+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                x_q <= '0;
                c_q <= 1'b0;
            end else if (en[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    x_q <= x_d;
                    c_q <= c_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // only the not-yet-added upper chunks of b travel on
            logic [YIN-CHUNK-1:0] y_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q <= '0;
                end else if (en[k] && v_in) begin
                    y_q <= y_in[YIN-1:CHUNK];
                end
            end
        end else begin : g_last
            assign bus.out_valid = v_q;
            assign bus.sum       = x_q;
            assign bus.co        = c_q;
`ifdef PIPE_ADD_OVF_EN
            logic ovf_d;
            logic ovf_q;

            // carry into the MSB is recovered from the MSB sum bit
            assign ovf_d = x_in[N-1] ^ y_in[CHUNK-1] ^ s_d[CHUNK-1] ^ c_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en[k] && v_in) begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.ovf = ovf_q;
`endif
        end
    end
endmodule
